test_stream_sink: RTL and testbench
===================================

Name: test_stream_sink

Overview:
Parametrised, cycle-accurate stream sink for unit-test benches. It consumes a val/rdy message stream from a DUT and compares each message in order against a preloaded table of expected messages. It optionally inserts pseudo-random backpressure, counts mismatches and cycles, and enforces a timeout. Benches instantiate one sink per DUT output channel, alongside the clock/reset generator.

Parameters:
p_msg_nbits, 32, width of each message.
p_num_msgs, 16, depth of the expected-message table (≥2); index width is clog2(p_num_msgs).
p_delay_mask, 0, random-delay mask on LFSR[7:0]; 0 disables backpressure. Must be 2^k−1.
p_seed, 32'hdeadbeef, LFSR reset value (non-zero).
p_timeout, 10000, cycles allowed in RUN before a timeout is declared.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
load_en  input  1  write expected message into table
load_idx  input  clog2(p_num_msgs)  table write index
load_msg  input  p_msg_nbits  table write data
num_msgs  input  clog2(p_num_msgs)+1  number of messages to expect, 0..p_num_msgs; sampled on start
start  input  1  begin checking
recv_val  input  1  DUT message valid
recv_rdy  output  1  sink ready
recv_msg  input  p_msg_nbits  DUT message
done  output  1  all expected messages received, sticky
failed  output  1  any mismatch or timeout, sticky
timeout  output  1  timeout occurred, sticky
err_count  output  clog2(p_num_msgs)+1  number of mismatching messages
first_err_idx  output  clog2(p_num_msgs)  index of first mismatch
cycles  output  32  cycles spent in RUN

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- On rst:
  - State goes to IDLE; all outputs and counters are 0.
  - LFSR = p_seed; delay counter = 0.
  - Table contents are not reset.
- States: IDLE, RUN, DONE, TOUT.
- IDLE:
  - recv_rdy=0.
  - load_en writes table[load_idx] on the clock edge. load_en is legal only in IDLE and is ignored in other states.
  - start=1 captures num_msgs and clears idx, err_count and cycles.
  - If num_msgs is 0, go to DONE (done=1 next cycle); otherwise go to RUN.
- RUN:
  - cycles increments every cycle.
  - recv_rdy = (delay_cnt==0). This is a registered-state decode only; it has no combinational path from recv_val.
  - Transfer happens when recv_val && recv_rdy. On a transfer:
    - Compare recv_msg with table[idx] using 4-state inequality in simulation; any X/Z bit counts as a mismatch.
    - On mismatch: err_count++ and failed=1. If err_count was 0, first_err_idx=idx.
    - idx++.
    - Reload delay_cnt = LFSR[7:0] & p_delay_mask.
    - Advance LFSR one step: lfsr <= {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}.
  - If delay_cnt is non-zero, it decrements each cycle regardless of recv_val.
  - The transfer of the last message (idx == num_msgs−1) moves the state to DONE; done=1 on the following cycle.
  - When cycles == p_timeout−1 and no final transfer happens this cycle, go to TOUT: timeout=1, failed=1.
  - A final transfer in the same cycle as the timeout condition wins: the state goes to DONE, not TOUT.
- DONE / TOUT:
  - recv_rdy=0; cycles frozen.
  - The state is held until rst; start is ignored.
- With p_delay_mask=0, recv_rdy=1 throughout RUN, giving one transfer per cycle at full throughput.
- A rst asserted mid-RUN aborts checking and returns to IDLE with all status cleared. The table is retained, so a bench can restart without reloading.
- Width rules:
  - err_count saturates at p_num_msgs (cannot be exceeded).
  - cycles is a 32-bit wrapping counter, but is bounded by p_timeout in practice.
- Simulation-only: on the first mismatch, print cycle, index, and received/expected values in hex. Synthesis ignores this.

Test Plan:
- Load 4 messages {0x11,0x22,0x33,0x44}, num_msgs=4, p_delay_mask=0, DUT drives matching messages with val held high → recv_rdy=1 every RUN cycle, done=1 on the 5th cycle after start, failed=0, err_count=0, cycles=4.
- Same table, DUT sends 0x11,0x99,0x33,0x55 → err_count=2, first_err_idx=1, failed=1, done=1.
- p_delay_mask=7, 8 matching messages → recv_rdy low between transfers for the LFSR-predicted counts from 0xdeadbeef, all 8 accepted, done=1, failed=0; no transfer ever occurs while recv_rdy=0.
- p_timeout=20, num_msgs=4, DUT sends only 2 messages → TOUT entered after cycles=19, timeout=1, failed=1, done=0, recv_rdy=0.
- Final transfer on cycle p_timeout−1 → done=1, timeout=0. Separately, num_msgs=0 with start → done=1 one cycle later, cycles=0.
- rst mid-RUN after 2 of 4 transfers, then start again without reloading → all status cleared, full run of 4 matching messages completes with done=1 and err_count=0.

Source files
------------

// File: rtl/test_stream_sink.sv
// Stream sink for unit-test benches: checks an incoming val/rdy stream against a
// preloaded table of expected messages, with optional random backpressure and a timeout.
module test_stream_sink #(
    parameter int unsigned p_msg_nbits  = 32,
    parameter int unsigned p_num_msgs   = 16,
    parameter int unsigned p_delay_mask = 0,
    parameter logic [31:0] p_seed       = 32'hdeadbeef,
    parameter int unsigned p_timeout    = 10000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load_en,
    input  logic [$clog2(p_num_msgs)-1:0]   load_idx,
    input  logic [p_msg_nbits-1:0]          load_msg,
    input  logic [$clog2(p_num_msgs):0]     num_msgs,
    input  logic                            start,
    input  logic                            recv_val,
    output logic                            recv_rdy,
    input  logic [p_msg_nbits-1:0]          recv_msg,
    output logic                            done,
    output logic                            failed,
    output logic                            timeout,
    output logic [$clog2(p_num_msgs):0]     err_count,
    output logic [$clog2(p_num_msgs)-1:0]   first_err_idx,
    output logic [31:0]                     cycles
);

    localparam int unsigned IW = $clog2(p_num_msgs);
    localparam int unsigned CW = IW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE, TOUT} state_t;

    state_t                 state, state_next;
    logic [p_msg_nbits-1:0] mem [p_num_msgs];
    logic [IW-1:0]          idx;
    logic [CW-1:0]          n_msgs;
    logic [31:0]            lfsr;
    logic [7:0]             delay_cnt;
    logic                   xfer, last, mismatch;

    assign recv_rdy = (state == RUN) && (delay_cnt == '0);
    assign done     = (state == DONE);
    assign timeout  = (state == TOUT);
    assign xfer     = recv_val && recv_rdy;
    assign last     = xfer && (CW'(idx) == n_msgs - CW'(1));
    // Case inequality so any X/Z bit on the received message counts as an error.
    assign mismatch = (recv_msg !== mem[idx]);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = (num_msgs == '0) ? DONE : RUN;
            RUN: begin
                if (last)                                state_next = DONE;
                else if (cycles == 32'(p_timeout - 1))   state_next = TOUT;
            end
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if ((state == IDLE) && load_en) mem[load_idx] <= load_msg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx           <= '0;
            n_msgs        <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            cycles        <= '0;
            failed        <= 1'b0;
            lfsr          <= p_seed;
            delay_cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        n_msgs        <= num_msgs;
                        idx           <= '0;
                        err_count     <= '0;
                        first_err_idx <= '0;
                        cycles        <= '0;
                    end
                end
                RUN: begin
                    cycles <= cycles + 32'd1;
                    if (state_next == TOUT) failed <= 1'b1;
                    if (delay_cnt != '0) delay_cnt <= delay_cnt - 8'd1;
                    if (xfer) begin
                        if (mismatch) begin
                            failed <= 1'b1;
                            if (err_count != CW'(p_num_msgs)) err_count <= err_count + CW'(1);
                            if (err_count == '0) first_err_idx <= idx;
                        end
                        idx       <= idx + IW'(1);
                        delay_cnt <= lfsr[7:0] & 8'(p_delay_mask);
                        lfsr      <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && xfer && mismatch && (err_count == '0))
            $display("test_stream_sink: first miscompare at cycle %0d idx %0d recv %h expected %h",
                     cycles, idx, recv_msg, mem[idx]);
    end
`endif

endmodule

// File: tb/tb_test_stream_sink.sv
// Directed and randomized checks of test_stream_sink: one full-throughput instance with a
// short timeout, one with LFSR backpressure checked against a schedule-level model.
module tb_test_stream_sink;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, load_en = 1'b0, start = 1'b0;
    logic [3:0]  load_idx = '0;
    logic [31:0] load_msg = '0;
    logic [4:0]  num_msgs = '0;

    logic        a_val = 1'b0, a_rdy, a_done, a_failed, a_timeout;
    logic [31:0] a_msg = '0, a_cycles;
    logic [4:0]  a_err;
    logic [3:0]  a_fei;
    logic        b_val = 1'b0, b_rdy, b_done, b_failed, b_timeout;
    logic [31:0] b_msg = '0, b_cycles;
    logic [4:0]  b_err;
    logic [3:0]  b_fei;

    test_stream_sink #(.p_msg_nbits(32), .p_num_msgs(16), .p_delay_mask(0),
                       .p_seed(32'hdeadbeef), .p_timeout(20)) dut_a (
        .clk(clk), .rst(rst), .load_en(load_en), .load_idx(load_idx), .load_msg(load_msg),
        .num_msgs(num_msgs), .start(start), .recv_val(a_val), .recv_rdy(a_rdy),
        .recv_msg(a_msg), .done(a_done), .failed(a_failed), .timeout(a_timeout),
        .err_count(a_err), .first_err_idx(a_fei), .cycles(a_cycles));

    test_stream_sink #(.p_msg_nbits(32), .p_num_msgs(16), .p_delay_mask(7),
                       .p_seed(32'hdeadbeef), .p_timeout(10000)) dut_b (
        .clk(clk), .rst(rst), .load_en(load_en), .load_idx(load_idx), .load_msg(load_msg),
        .num_msgs(num_msgs), .start(start), .recv_val(b_val), .recv_rdy(b_rdy),
        .recv_msg(b_msg), .done(b_done), .failed(b_failed), .timeout(b_timeout),
        .err_count(b_err), .first_err_idx(b_fei), .cycles(b_cycles));

    int n_cmp = 0, n_bad = 0;
    logic [31:0] tab [16];
    logic [31:0] snd [16];
    int exp_err, exp_fei, b_c;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_table(input int n);
        for (int i = 0; i < n; i++) begin
            load_en = 1'b1; load_idx = 4'(i); load_msg = tab[i];
            tick();
        end
        load_en = 1'b0;
    endtask

    task automatic start_run(input int n);
        num_msgs = 5'(n); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Expected error count / first error index straight from the sent-vs-table rule.
    task automatic model_errs(input int n);
        exp_err = 0; exp_fei = 0;
        for (int i = 0; i < n; i++)
            if (snd[i] !== tab[i]) begin
                if (exp_err == 0) exp_fei = i;
                exp_err++;
            end
    endtask

    task automatic run_a(input int first, input int n);
        for (int k = first; k < first + n; k++) begin
            check("a_rdy_full_rate", a_rdy, 1);
            a_msg = snd[k]; a_val = 1'b1;
            tick();
        end
        a_val = 1'b0;
    endtask

    task automatic check_a(input string tag, input logic d, input logic f, input logic t,
                           input int e, input int fe, input int c);
        check({tag, "_done"}, a_done, d);
        check({tag, "_failed"}, a_failed, f);
        check({tag, "_timeout"}, a_timeout, t);
        check({tag, "_err"}, a_err, e);
        check({tag, "_fei"}, a_fei, fe);
        check({tag, "_cycles"}, a_cycles, c);
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    // After a transfer at RUN cycle t with drawn delay d, ready stays low for d cycles.
    task automatic run_b(input int n, input bit corrupt);
        logic [31:0] lf, m;
        int last_t, d, k;
        bit v, er;
        lf = 32'hdeadbeef; last_t = 0; d = 0; k = 0; b_c = 0;
        exp_err = 0; exp_fei = 0;
        while (k < n && b_c < 400) begin
            b_c++;
            er = ((b_c - last_t - 1) >= d);
            check("b_rdy_schedule", b_rdy, er);
            v = ($urandom_range(0, 3) != 0);
            m = tab[k];
            if (corrupt && $urandom_range(0, 2) == 0) m = m ^ (32'h1 << $urandom_range(0, 31));
            b_val = v;
            b_msg = v ? m : $urandom;
            tick();
            if (v && er) begin
                if (m !== tab[k]) begin
                    if (exp_err == 0) exp_fei = k;
                    exp_err++;
                end
                d = int'(lf[7:0] & 8'h07);
                lf = lfsr_next(lf);
                last_t = b_c;
                k++;
            end
        end
        b_val = 1'b0;
        check("b_all_accepted", k, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check_a("reset", 0, 0, 0, 0, 0, 0);
        check("reset_rdy", a_rdy, 0);
        check("reset_b_rdy", b_rdy, 0);

        // Matching stream at full rate.
        tab[0] = 32'h11; tab[1] = 32'h22; tab[2] = 32'h33; tab[3] = 32'h44;
        load_table(4);
        check("idle_rdy", a_rdy, 0);
        start_run(4);
        for (int i = 0; i < 4; i++) snd[i] = tab[i];
        run_a(0, 3);
        check("done_not_early", a_done, 0);
        run_a(3, 1);
        check_a("match", 1, 0, 0, 0, 0, 4);
        check("match_rdy_after", a_rdy, 0);
        tick();
        check("done_sticky", a_done, 1);

        // Two corrupted messages.
        do_reset();
        snd[1] = 32'h99; snd[3] = 32'h55;
        model_errs(4);
        start_run(4);
        run_a(0, 4);
        check_a("mism", 1, 1, 0, exp_err, exp_fei, 4);

        // Only 2 of 4 arrive: timeout after 20 RUN cycles; loads outside IDLE ignored.
        do_reset();
        for (int i = 0; i < 4; i++) snd[i] = tab[i];
        start_run(4);
        run_a(0, 2);
        load_en = 1'b1; load_idx = 4'd0; load_msg = 32'hdead;
        tick();
        load_en = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        check("pre_tout_cycles", a_cycles, 19);
        check("pre_tout_timeout", a_timeout, 0);
        tick();
        check_a("tout", 0, 1, 1, 0, 0, 20);
        check("tout_rdy", a_rdy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_a("tout_hold", 0, 1, 1, 0, 0, 20);

        // Final transfer exactly on the timeout cycle wins.
        do_reset();
        start_run(4);
        run_a(0, 3);
        for (int i = 0; i < 16; i++) tick();
        check("edge_cycles", a_cycles, 19);
        run_a(3, 1);
        check_a("edge_done", 1, 0, 0, 0, 0, 20);

        // Empty run.
        do_reset();
        start_run(0);
        check_a("empty", 1, 0, 0, 0, 0, 0);
        check("empty_rdy", a_rdy, 0);

        // Reset mid-run, then restart without reloading.
        do_reset();
        snd[1] = 32'h77;
        start_run(4);
        run_a(0, 2);
        check("mid_err", a_err, 1);
        check("mid_fei", a_fei, 1);
        do_reset();
        check_a("mid_rst", 0, 0, 0, 0, 0, 0);
        snd[1] = tab[1];
        start_run(4);
        run_a(0, 4);
        check_a("restart", 1, 0, 0, 0, 0, 4);

        // Backpressure instance: random table, random valid, LFSR-driven ready gaps.
        do_reset();
        for (int i = 0; i < 8; i++) tab[i] = $urandom;
        load_table(8);
        start_run(8);
        run_b(8, 1'b0);
        check("b_done", b_done, 1);
        check("b_failed", b_failed, 0);
        check("b_err", b_err, 0);
        check("b_cycles", b_cycles, b_c);

        do_reset();
        start_run(8);
        run_b(8, 1'b1);
        check("b2_done", b_done, 1);
        check("b2_failed", b_failed, (exp_err != 0) ? 1 : 0);
        check("b2_err", b_err, exp_err);
        check("b2_fei", b_fei, exp_fei);
        check("b2_cycles", b_cycles, b_c);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
